// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester IDs
// and default bus widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_ICACHE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side busywait ports for both caches plus the main-memory port.
// Handshake: a requester holds READx/WRITEx, ADDRx and WDATAx and stalls while
// BUSYWAITx is high. BUSYWAITx drops for exactly one cycle, during which RDATAx
// is valid for reads. Memory raises MEM_BUSYWAIT to accept a command and drops
// it with MEM_RDATA valid when the access is complete.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  READ0, WRITE0, BUSYWAIT0;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic [DATA_WIDTH-1:0] WDATA0, RDATA0;
    logic                  READ1, WRITE1, BUSYWAIT1;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic [DATA_WIDTH-1:0] WDATA1, RDATA1;
    logic                  MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_WDATA, MEM_RDATA;

    // Arbiter side.
    modport slave (
        input  READ0, WRITE0, ADDR0, WDATA0, READ1, WRITE1, ADDR1, WDATA1,
               MEM_RDATA, MEM_BUSYWAIT,
        output BUSYWAIT0, RDATA0, BUSYWAIT1, RDATA1,
               MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );

    // Caches plus memory, as seen from outside the arbiter.
    modport master (
        output READ0, WRITE0, ADDR0, WDATA0, READ1, WRITE1, ADDR1, WDATA1,
               MEM_RDATA, MEM_BUSYWAIT,
        input  BUSYWAIT0, RDATA0, BUSYWAIT1, RDATA1,
               MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// Generic 2-to-1 mux used for memory-side address and data steering.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-request round-robin pick: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    assign grant_valid = req0 | req1;
    assign grant       = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the data cache (0) and instruction
// cache (1) with round-robin fairness and a latched, sequenced transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    mem_port_arbiter_if.slave      bus,
    output state_t                 dbg_state,
    output logic                   dbg_grant
);
    state_t                state;
    logic                  grant, last_grant;
    logic                  mem_read, mem_write;
    logic [ADDR_WIDTH-1:0] addr_lat0, addr_lat1;
    logic [DATA_WIDTH-1:0] wdata_lat0, wdata_lat1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  req0, req1, pick_valid, pick, pick_write;

    assign req0 = bus.READ0 | bus.WRITE0;
    assign req1 = bus.READ1 | bus.WRITE1;

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant_valid(pick_valid),
        .grant      (pick)
    );

    // READ and WRITE together is illegal; the write wins.
    assign pick_write = pick ? bus.WRITE1 : bus.WRITE0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            grant      <= REQ_DCACHE;
            last_grant <= REQ_ICACHE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            addr_lat0  <= '0;
            addr_lat1  <= '0;
            wdata_lat0 <= '0;
            wdata_lat1 <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        mem_read   <= ~pick_write;
                        mem_write  <= pick_write;
                        addr_lat0  <= bus.ADDR0;
                        addr_lat1  <= bus.ADDR1;
                        wdata_lat0 <= bus.WDATA0;
                        wdata_lat1 <= bus.WDATA1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.MEM_BUSYWAIT) state <= WAIT;
                end
                WAIT: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!mem_write) begin
                            if (grant == REQ_ICACHE) rdata1 <= bus.MEM_RDATA;
                            else                     rdata0 <= bus.MEM_RDATA;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
        .sel(grant), .a(addr_lat0), .b(addr_lat1), .y(bus.MEM_ADDR)
    );
    mux2 #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
        .sel(grant), .a(wdata_lat0), .b(wdata_lat1), .y(bus.MEM_WDATA)
    );

    assign bus.MEM_READ  = mem_read;
    assign bus.MEM_WRITE = mem_write;
    assign bus.RDATA0    = rdata0;
    assign bus.RDATA1    = rdata1;

    // A requester stalls until its own DONE cycle.
    assign bus.BUSYWAIT0 = req0 & ~((state == DONE) && (grant == REQ_DCACHE));
    assign bus.BUSYWAIT1 = req1 & ~((state == DONE) && (grant == REQ_ICACHE));

    assign dbg_state = state;
    assign dbg_grant = grant;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both caches and main
// memory, stepping on falling edges and checking against hand-computed values.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t dbg_state;
    logic   dbg_grant;
    int     n_checks = 0;
    int     n_fails  = 0;
    logic [31:0] rdata0_exp, rdata1_exp;

    mem_port_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .bus      (bus.slave),
        .dbg_state(dbg_state),
        .dbg_grant(dbg_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!(bus.MEM_READ || bus.MEM_WRITE) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issue_timeout"}, 64'(n < 20), 64'd1);
    endtask

    // Called in ISSUE: memory stays busy busy_n cycles, then returns rd.
    task automatic mem_serve(input string tag, input int busy_n, input logic [31:0] rd);
        bus.MEM_BUSYWAIT = 1'b1;
        repeat (busy_n) tick();
        check({tag, "_wait"}, dbg_state, WAIT);
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_RDATA    = rd;
        tick();
        check({tag, "_done"}, dbg_state, DONE);
    endtask

    initial begin
        bus.READ0 = 0; bus.WRITE0 = 0; bus.ADDR0 = '0; bus.WDATA0 = '0;
        bus.READ1 = 0; bus.WRITE1 = 0; bus.ADDR1 = '0; bus.WDATA1 = '0;
        bus.MEM_BUSYWAIT = 0; bus.MEM_RDATA = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        check("rst_state", dbg_state, IDLE);
        check("rst_grant", dbg_grant, 0);
        check("rst_mem_rw", {bus.MEM_READ, bus.MEM_WRITE}, 0);
        check("rst_mem_addr", bus.MEM_ADDR, 0);
        check("rst_mem_wdata", bus.MEM_WDATA, 0);
        check("rst_rdata", {bus.RDATA0, bus.RDATA1}, 0);
        rst_n = 1'b1;
        tick();

        // Single read from the data cache.
        bus.READ0 = 1; bus.ADDR0 = 6'h05;
        #1 check("rd_bw0_req", bus.BUSYWAIT0, 1);
        check("rd_bw1_idle", bus.BUSYWAIT1, 0);
        tick();
        check("rd_issue", dbg_state, ISSUE);
        check("rd_mem_read", {bus.MEM_READ, bus.MEM_WRITE}, 2'b10);
        check("rd_mem_addr", bus.MEM_ADDR, 6'h05);
        mem_serve("rd", 5, 32'hDEADBEEF);
        check("rd_bw0_done", bus.BUSYWAIT0, 0);
        check("rd_rdata0", bus.RDATA0, 32'hDEADBEEF);
        check("rd_mem_off", {bus.MEM_READ, bus.MEM_WRITE}, 0);
        check("rd_bw1", bus.BUSYWAIT1, 0);
        bus.READ0 = 0;
        tick();
        check("rd_back_idle", dbg_state, IDLE);

        // Reset in the middle of WAIT aborts the transaction.
        bus.READ0 = 1; bus.ADDR0 = 6'h0A;
        tick();
        bus.MEM_BUSYWAIT = 1;
        tick();
        tick();
        check("mrst_pre_wait", dbg_state, WAIT);
        rst_n = 1'b0;
        #1;
        check("mrst_state", dbg_state, IDLE);
        check("mrst_mem_read", bus.MEM_READ, 0);
        check("mrst_rdata0", bus.RDATA0, 0);
        check("mrst_bw0", bus.BUSYWAIT0, 1);
        bus.MEM_BUSYWAIT = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_rerun_issue", dbg_state, ISSUE);
        check("mrst_rerun_addr", bus.MEM_ADDR, 6'h0A);
        check("mrst_rerun_read", bus.MEM_READ, 1);
        mem_serve("mrst", 2, 32'hCAFE0001);
        check("mrst_rdata0", bus.RDATA0, 32'hCAFE0001);
        bus.READ0 = 0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous requests straight after reset: data cache first.
        bus.READ0 = 1; bus.ADDR0 = 6'h11;
        bus.READ1 = 1; bus.ADDR1 = 6'h22;
        tick();
        check("sim_grant0", dbg_grant, REQ_DCACHE);
        check("sim_addr0", bus.MEM_ADDR, 6'h11);
        check("sim_bw1_issue", bus.BUSYWAIT1, 1);
        mem_serve("sim0", 1, 32'hA0A0A0A0);
        check("sim_bw0_done", bus.BUSYWAIT0, 0);
        check("sim_bw1_done0", bus.BUSYWAIT1, 1);
        check("sim_rdata0", bus.RDATA0, 32'hA0A0A0A0);
        check("sim_rdata1_hold", bus.RDATA1, 0);
        bus.READ0 = 0;
        tick();
        check("sim_gap_idle", dbg_state, IDLE);
        check("sim_gap_bw1", bus.BUSYWAIT1, 1);
        tick();
        check("sim_grant1", dbg_grant, REQ_ICACHE);
        check("sim_addr1", bus.MEM_ADDR, 6'h22);
        mem_serve("sim1", 1, 32'hB1B1B1B1);
        check("sim_bw1_done", bus.BUSYWAIT1, 0);
        check("sim_rdata1", bus.RDATA1, 32'hB1B1B1B1);
        check("sim_rdata0_hold", bus.RDATA0, 32'hA0A0A0A0);
        bus.READ1 = 0;
        tick();

        // Continuous contention: grants alternate 0,1,0,1.
        rdata0_exp = 32'hA0A0A0A0;
        rdata1_exp = 32'hB1B1B1B1;
        bus.READ0 = 1; bus.ADDR0 = 6'h01;
        bus.READ1 = 1; bus.ADDR1 = 6'h02;
        for (int i = 0; i < 4; i++) begin
            logic g;
            logic [31:0] d;
            g = i[0];
            d = 32'h10000000 + 32'(i);
            wait_mem_req($sformatf("rr%0d", i));
            check($sformatf("rr%0d_grant", i), dbg_grant, g);
            check($sformatf("rr%0d_addr", i), bus.MEM_ADDR, g ? 6'h02 : 6'h01);
            mem_serve($sformatf("rr%0d", i), 1 + i, d);
            if (g) rdata1_exp = d; else rdata0_exp = d;
            check($sformatf("rr%0d_bw_done", i), {bus.BUSYWAIT1, bus.BUSYWAIT0}, g ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_rdata", i), {bus.RDATA1, bus.RDATA0}, {rdata1_exp, rdata0_exp});
            tick();
            check($sformatf("rr%0d_pulse_end", i), {bus.BUSYWAIT1, bus.BUSYWAIT0}, 2'b11);
            check($sformatf("rr%0d_idle", i), dbg_state, IDLE);
        end
        bus.READ0 = 0; bus.READ1 = 0;
        tick();

        // Write whose requester inputs change after the grant.
        bus.WRITE1 = 1; bus.ADDR1 = 6'h3F; bus.WDATA1 = 32'h12345678;
        tick();
        check("wr_grant", dbg_grant, REQ_ICACHE);
        check("wr_mem_rw", {bus.MEM_READ, bus.MEM_WRITE}, 2'b01);
        check("wr_wdata_issue", bus.MEM_WDATA, 32'h12345678);
        bus.MEM_BUSYWAIT = 1;
        tick();
        bus.WDATA1 = 32'h0; bus.ADDR1 = 6'h00;
        tick();
        check("wr_wdata_wait", bus.MEM_WDATA, 32'h12345678);
        check("wr_addr_wait", bus.MEM_ADDR, 6'h3F);
        bus.MEM_BUSYWAIT = 0; bus.MEM_RDATA = 32'hFFFFFFFF;
        tick();
        check("wr_done", dbg_state, DONE);
        check("wr_wdata_done", bus.MEM_WDATA, 32'h12345678);
        check("wr_mem_off", bus.MEM_WRITE, 0);
        check("wr_rdata1_hold", bus.RDATA1, rdata1_exp);
        bus.WRITE1 = 0;
        tick();

        // Illegal READ+WRITE is performed as a write.
        bus.READ0 = 1; bus.WRITE0 = 1; bus.ADDR0 = 6'h07; bus.WDATA0 = 32'h00000077;
        tick();
        check("rw_mem_rw", {bus.MEM_READ, bus.MEM_WRITE}, 2'b01);
        check("rw_wdata", bus.MEM_WDATA, 32'h00000077);
        mem_serve("rw", 1, 32'hEEEEEEEE);
        check("rw_rdata0_hold", bus.RDATA0, rdata0_exp);
        bus.READ0 = 0; bus.WRITE0 = 0;
        tick();

        // Request dropped mid-transaction, with data cache pending.
        bus.READ1 = 1; bus.ADDR1 = 6'h15;
        tick();
        check("drop_grant1", dbg_grant, REQ_ICACHE);
        bus.MEM_BUSYWAIT = 1;
        bus.READ0 = 1; bus.ADDR0 = 6'h2A;
        tick();
        bus.READ1 = 0;
        #1 check("drop_bw1", bus.BUSYWAIT1, 0);
        check("drop_bw0", bus.BUSYWAIT0, 1);
        tick();
        bus.MEM_BUSYWAIT = 0; bus.MEM_RDATA = 32'h5A5A5A5A;
        tick();
        check("drop_done", dbg_state, DONE);
        check("drop_rdata1", bus.RDATA1, 32'h5A5A5A5A);
        check("drop_bw0_done", bus.BUSYWAIT0, 1);
        tick();
        check("drop_idle", dbg_state, IDLE);
        tick();
        check("drop_next_grant", dbg_grant, REQ_DCACHE);
        check("drop_next_addr", bus.MEM_ADDR, 6'h2A);
        check("drop_next_read", bus.MEM_READ, 1);
        mem_serve("drop_next", 1, 32'h0F0F0F0F);
        check("drop_next_rdata0", bus.RDATA0, 32'h0F0F0F0F);
        bus.READ0 = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the data cache (requester 0) and the instruction cache (requester 1).
- Replaces ad-hoc select wiring around the shared memory bus. Sequences each memory transaction and drives the memory-side select internally.
- Uses round-robin arbitration so neither requester starves. Each requester sees the CO224 busywait handshake unchanged.

Parameters:
- ADDR_WIDTH, 6, block address width on both requester and memory side.
- DATA_WIDTH, 32, memory block width.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- READ0 / WRITE0  input  1 each  data-cache request.
- ADDR0  input  ADDR_WIDTH  data-cache address.
- WDATA0  input  DATA_WIDTH  data-cache write block.
- BUSYWAIT0  output  1  stall to data cache.
- RDATA0  output  DATA_WIDTH  read block to data cache.
- READ1 / WRITE1 / ADDR1 / WDATA1 / BUSYWAIT1 / RDATA1: same as above, for the instruction cache.
- MEM_READ / MEM_WRITE  output  1 each  to main memory.
- MEM_ADDR  output  ADDR_WIDTH  to main memory.
- MEM_WDATA  output  DATA_WIDTH  to main memory.
- MEM_RDATA  input  DATA_WIDTH  from main memory.
- MEM_BUSYWAIT  input  1  memory busy.

Behaviour:
- Reset (async, RESET_N low): state=IDLE; grant=0; last_grant=1 (so data cache wins the first tie); MEM_READ=MEM_WRITE=0; MEM_ADDR, MEM_WDATA, RDATA0, RDATA1 = 0. Reset mid-transaction aborts immediately and no completion is signalled.
- reqX = READX | WRITEX. READX and WRITEX high together is illegal; it is treated as a write.
- BUSYWAITX (combinational) = reqX & ~(state==DONE & grant==X). A requester stalls from the cycle it requests until its DONE cycle.
- States:
  - IDLE: if neither req, stay. If exactly one req, grant it. If both, grant ~last_grant. On the edge, latch grant, op (read/write), ADDRx and WDATAx into internal registers. Next state ISSUE.
  - ISSUE: MEM_READ/MEM_WRITE asserted per latched op; MEM_ADDR/MEM_WDATA come from the latches. When MEM_BUSYWAIT=1, go to WAIT; otherwise stay.
  - WAIT: memory outputs held. When MEM_BUSYWAIT=0, capture MEM_RDATA into RDATA[grant] (reads only) and go to DONE.
  - DONE: MEM_READ=MEM_WRITE=0; BUSYWAIT[grant]=0 for exactly this cycle; last_grant<=grant. Next state IDLE.
- Latency: request visible at cycle 0 → ISSUE at 1 → WAIT at 2 → ... DONE one cycle after MEM_BUSYWAIT falls. Back-to-back requests cost one IDLE cycle between transactions.
- Latched request: memory-side address and data come only from the latched registers. Requester inputs changing after the grant edge have no effect on the transaction.
- Request dropped mid-transaction: the transaction still completes. RDATA is still updated, and BUSYWAIT is already low because reqX=0.
- Non-granted requester: its RDATA holds its previous value; its BUSYWAIT stays high while it requests.
- Fairness: while both request continuously, grants alternate 0,1,0,1. The worst-case wait is one foreign transaction.
- The arbiter has no timeout; MEM_BUSYWAIT stuck high holds WAIT indefinitely.

Decomposition:
- Shared package/header: state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and the requester IDs (REQ_DCACHE=0, REQ_ICACHE=1).
- One sub-module is natural: rr_arbiter2, a combinational two-request round-robin pick taking (req0, req1, last_grant) and producing (grant_valid, grant).
- Memory-side address/data steering reuses the existing 2-to-1 mux unit, instantiated per field and selected by the latched grant.
- The remaining FSM, latches and RDATA registers stay in the top module.

Test Plan:
- Reset: RESET_N low mid-WAIT with READ0=1 → MEM_READ=0, RDATA0=0 and state IDLE immediately. After RESET_N high, the transaction re-runs from IDLE.
- Single read: READ0=1, ADDR0=6'h05; memory busy 5 cycles, returns 32'hDEADBEEF → MEM_ADDR=6'h05 from cycle 1. DONE arrives one cycle after busywait falls with BUSYWAIT0=0 and RDATA0=32'hDEADBEEF. BUSYWAIT1 stays 0 throughout.
- Simultaneous requests after reset: READ0 and READ1 raised at the same edge → data cache is served first and BUSYWAIT1 stays high throughout. The instruction cache is issued after one IDLE cycle.
- Continuous contention: both requesting for 4 transactions → grant order 0,1,0,1, and each requester's DONE pulse lasts exactly one cycle.
- Write with input change: WRITE1=1, WDATA1=32'h12345678, then WDATA1 changed to 0 during WAIT → MEM_WDATA stays 32'h12345678 until DONE and RDATA1 is unchanged.
- Drop mid-transaction: READ1 deasserted during WAIT → the transaction finishes, RDATA1 is updated, and the next IDLE cycle grants a pending READ0.
